// File: rtl/processador_pio_seq.sv
// Pattern sequencer for the processador 3-bit output PIO.
// A config slave holds the patterns, dwell and length; a master strobes the patterns into the PIO.
module processador_pio_seq #(
  parameter int unsigned DWELL_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [3:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  output logic [1:0]         m_address,
  output logic               m_chipselect,
  output logic               m_write_n,
  output logic [31:0]        m_writedata,
  output logic               irq
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned PAT_W  = 3;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned N_PAT  = 8;

  typedef enum logic [1:0] {S_IDLE, S_STROBE, S_WAIT} state_t;

  state_t             r_state;
  logic               r_run;
  logic               r_loop;
  logic               r_ie;
  logic               r_done;
  logic               r_irq;
  logic [IDX_W-1:0]   r_index;
  logic [DWELL_W-1:0] r_dwell;
  logic [DWELL_W-1:0] r_cnt;
  logic [IDX_W-1:0]   r_length;
  logic [PAT_W-1:0]   r_pat [N_PAT];
  logic               r_m_cs;
  logic               r_m_wr_n;
  logic [PAT_W-1:0]   r_m_pat;

  logic               w_wr;
  logic               w_ctrl_wr;
  logic               w_stat_wr;
  logic               w_busy;
  logic               w_start;
  logic               w_abort;
  logic               w_adv;
  logic [IDX_W-1:0]   w_last;
  logic               w_more;
  logic               w_finish;
  logic [IDX_W-1:0]   w_next_idx;
  logic               w_run_nxt;
  logic               w_ie_nxt;
  logic               w_done_nxt;
  logic               w_unused;

  // Slave decode and the outcome of an advance; LENGTH 0 wraps to a last index of 7.
  always_comb begin
    w_wr       = chipselect & ~write_n;
    w_ctrl_wr  = w_wr && (address == 4'd0);
    w_stat_wr  = w_wr && (address == 4'd1);
    w_busy     = (r_state != S_IDLE);
    w_start    = w_ctrl_wr & writedata[0] & ~w_busy;
    w_abort    = w_ctrl_wr & ~writedata[0] & w_busy;
    w_adv      = ~w_abort &
                 (((r_state == S_STROBE) && (r_dwell == '0)) ||
                  ((r_state == S_WAIT) && (r_cnt == DWELL_W'(1))));
    w_last     = r_length - 3'd1;
    w_more     = (r_index < w_last);
    w_finish   = w_adv & ~w_more & ~r_loop;
    w_next_idx = w_more ? (r_index + 3'd1) : '0;
    w_run_nxt  = w_finish ? 1'b0 : (w_ctrl_wr ? writedata[0] : r_run);
    w_ie_nxt   = w_ctrl_wr ? writedata[2] : r_ie;
    if (w_finish)
      w_done_nxt = 1'b1;
    else if (w_start || (w_stat_wr && writedata[1]))
      w_done_nxt = 1'b0;
    else
      w_done_nxt = r_done;
    w_unused   = ^writedata[DATA_W-1:DWELL_W];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_run    <= 1'b0;
      r_loop   <= 1'b0;
      r_ie     <= 1'b0;
      r_done   <= 1'b0;
      r_irq    <= 1'b0;
      r_index  <= '0;
      r_dwell  <= '0;
      r_cnt    <= '0;
      r_length <= '0;
      for (int i = 0; i < N_PAT; i++) r_pat[i] <= '0;
      r_m_cs   <= 1'b0;
      r_m_wr_n <= 1'b1;
      r_m_pat  <= '0;
    end else begin
      r_run  <= w_run_nxt;
      r_loop <= w_ctrl_wr ? writedata[1] : r_loop;
      r_ie   <= w_ie_nxt;
      r_done <= w_done_nxt;
      r_irq  <= w_done_nxt & w_ie_nxt;
      if (w_wr && (address == 4'd2)) r_dwell <= writedata[DWELL_W-1:0];
      if (w_wr && (address == 4'd3)) r_length <= writedata[IDX_W-1:0];
      if (w_wr && address[3]) r_pat[address[2:0]] <= writedata[PAT_W-1:0];

      r_m_cs   <= 1'b0;
      r_m_wr_n <= 1'b1;
      r_m_pat  <= '0;
      case (r_state)
        S_IDLE: begin
          r_index <= '0;
          if (w_start) begin
            r_state  <= S_STROBE;
            r_m_cs   <= 1'b1;
            r_m_wr_n <= 1'b0;
            r_m_pat  <= r_pat[0];
          end
        end
        S_STROBE, S_WAIT: begin
          if (w_abort) begin
            r_state <= S_IDLE;
            r_index <= '0;
          end else if (w_adv) begin
            if (w_finish) begin
              r_state <= S_IDLE;
              r_index <= '0;
            end else begin
              r_state  <= S_STROBE;
              r_index  <= w_next_idx;
              r_m_cs   <= 1'b1;
              r_m_wr_n <= 1'b0;
              r_m_pat  <= r_pat[w_next_idx];
            end
          end else if (r_state == S_STROBE) begin
            r_cnt   <= r_dwell;
            r_state <= S_WAIT;
          end else begin
            r_cnt <= r_cnt - DWELL_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Config readback is combinational from the address.
  always_comb begin
    readdata = '0;
    if (address[3]) begin
      readdata = {29'b0, r_pat[address[2:0]]};
    end else begin
      case (address)
        4'd0:    readdata = {29'b0, r_ie, r_loop, r_run};
        4'd1:    readdata = {25'b0, r_index, 2'b0, r_done, w_busy};
        4'd2:    readdata = 32'(r_dwell);
        4'd3:    readdata = {29'b0, r_length};
        default: readdata = '0;
      endcase
    end
  end

  assign m_address    = 2'b00;
  assign m_chipselect = r_m_cs;
  assign m_write_n    = r_m_wr_n;
  assign m_writedata  = {29'b0, r_m_pat};
  assign irq          = r_irq;

endmodule

// File: tb/tb_processador_pio_seq.sv
// Self-checking bench for processador_pio_seq: register table, randomized runs
// against an arithmetic strobe-timing model, and loop/abort/reset corner sequences.
module tb_processador_pio_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
  logic        irq;

  processador_pio_seq #(.DWELL_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
    .m_writedata(m_writedata), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; logic [2:0] v; } strobe_t;
  strobe_t sq[$];
  logic [2:0] tp [8];

  typedef struct { logic [3:0] a; logic [31:0] wd; logic [31:0] exp; } vec_t;
  vec_t tbl [10];

  // Record every PIO write and check bus sanity each cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      if (m_chipselect && !m_write_n) sq.push_back('{cyc, m_writedata[2:0]});
      if ((m_chipselect == m_write_n) || (m_address != 2'd0) || (m_writedata[31:3] != 29'd0)) begin
        checks++;
        errors++;
        $display("FAIL bus_protocol cyc=%0d cs=%b wn=%b addr=%0d wd=%h", cyc,
                 m_chipselect, m_write_n, m_address, m_writedata);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, output int n);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    n = cyc;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    address = a;
    #1 d = readdata;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Program tp[], dwell and length, start, and check every strobe plus the finish timing.
  task automatic run_seq(input logic [2:0] len, input int d, input bit ie, input string tag);
    int n, t, l, dum;
    logic [31:0] s;
    for (int i = 0; i < 8; i++) wr(4'(8 + i), 32'(tp[i]), dum);
    wr(4'd2, 32'(d), dum);
    wr(4'd3, 32'(len), dum);
    sq.delete();
    wr(4'd0, {29'b0, ie, 1'b0, 1'b1}, n);
    l = (len == 3'd0) ? 8 : int'(len);
    t = n + l * (d + 1);
    wait_to(t - 1);
    rd(4'd1, s);
    chk({tag, " status_before_done"}, s, 32'(((l - 1) << 4) | 1));
    wait_to(t);
    rd(4'd1, s);
    chk({tag, " status_done"}, s, 32'h2);
    chk({tag, " irq"}, 32'(irq), 32'(ie));
    rd(4'd0, s);
    chk({tag, " ctrl_after"}, s, {29'b0, ie, 2'b00});
    wait_to(t + 4);
    chk({tag, " strobe_count"}, 32'(sq.size()), 32'(l));
    for (int k = 0; k < l && k < sq.size(); k++) begin
      chk($sformatf("%s strobe%0d_cycle", tag, k), 32'(sq[k].c), 32'(n + k * (d + 1)));
      chk($sformatf("%s strobe%0d_value", tag, k), 32'(sq[k].v), 32'(tp[k]));
    end
    wr(4'd1, 32'h2, dum);
    chk({tag, " irq_cleared"}, 32'(irq), 32'h0);
    rd(4'd1, s);
    chk({tag, " status_cleared"}, s, 32'h0);
  endtask

  initial begin
    int n, m, dum;
    logic [31:0] r;

    tbl[0] = '{4'd2,  32'hFFFF_1234, 32'h0000_1234};
    tbl[1] = '{4'd3,  32'hFFFF_FFFD, 32'h5};
    tbl[2] = '{4'd8,  32'hF,         32'h7};
    tbl[3] = '{4'd15, 32'h2,         32'h2};
    tbl[4] = '{4'd12, 32'h4,         32'h4};
    tbl[5] = '{4'd4,  32'hFFFF_FFFF, 32'h0};
    tbl[6] = '{4'd7,  32'h5,         32'h0};
    tbl[7] = '{4'd0,  32'h6,         32'h6};
    tbl[8] = '{4'd1,  32'hFFFF_FFFF, 32'h0};
    tbl[9] = '{4'd0,  32'h0,         32'h0};

    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
    repeat (3) @(negedge clk);
    chk("rst m_chipselect", 32'(m_chipselect), 32'h0);
    chk("rst m_write_n", 32'(m_write_n), 32'h1);
    chk("rst m_writedata", m_writedata, 32'h0);
    chk("rst m_address", 32'(m_address), 32'h0);
    chk("rst irq", 32'(irq), 32'h0);
    rd(4'd1, r); chk("rst status", r, 32'h0);
    rd(4'd0, r); chk("rst ctrl", r, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Register write/readback table
    for (int i = 0; i < 10; i++) begin
      wr(tbl[i].a, tbl[i].wd, dum);
      rd(tbl[i].a, r);
      chk($sformatf("reg_table%0d addr%0d", i, tbl[i].a), r, tbl[i].exp);
    end
    chk("no_strobe_from_cfg", 32'(sq.size()), 32'h0);

    tp = '{3'd5, 3'd2, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    run_seq(3'd3, 4, 1'b1, "basic");

    for (int i = 0; i < 8; i++) tp[i] = 3'(i);
    run_seq(3'd0, 0, 1'b0, "b2b8");

    for (int it = 0; it < 15; it++) begin
      for (int i = 0; i < 8; i++) tp[i] = 3'($urandom_range(0, 7));
      run_seq(3'($urandom_range(0, 7)), int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
              $sformatf("rand%0d", it));
    end

    // Loop run; clearing loop during a PAT[0] strobe ends after the following PAT[1]
    tp = '{3'd1, 3'd6, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    wr(4'd8, 32'd1, dum); wr(4'd9, 32'd6, dum); wr(4'd2, 32'd2, dum); wr(4'd3, 32'd2, dum);
    sq.delete();
    wr(4'd0, 32'h3, n);
    wait_to(n + 11);
    wr(4'd0, 32'h1, m);
    wait_to(n + 17);
    rd(4'd1, r); chk("loop status_before_done", r, 32'h11);
    wait_to(n + 18);
    rd(4'd1, r); chk("loop status_done", r, 32'h2);
    wait_to(n + 24);
    chk("loop strobe_count", 32'(sq.size()), 32'd6);
    for (int k = 0; k < 6 && k < sq.size(); k++) begin
      chk($sformatf("loop strobe%0d_cycle", k), 32'(sq[k].c), 32'(n + 3 * k));
      chk($sformatf("loop strobe%0d_value", k), 32'(sq[k].v), (k % 2 == 0) ? 32'd1 : 32'd6);
    end

    // Abort during WAIT, then restart from PAT[0]
    tp = '{3'd3, 3'd4, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    for (int i = 0; i < 8; i++) wr(4'(8 + i), 32'(tp[i]), dum);
    wr(4'd2, 32'd5, dum); wr(4'd3, 32'd3, dum);
    sq.delete();
    wr(4'd0, 32'h1, n);
    wait_to(n + 1);
    wr(4'd0, 32'h0, m);
    wait_to(n + 20);
    chk("abort strobe_count", 32'(sq.size()), 32'd1);
    rd(4'd1, r); chk("abort status", r, 32'h0);
    run_seq(3'd3, 5, 1'b0, "restart");

    // Done set and W1C on the same edge: set wins
    wr(4'd3, 32'd1, dum); wr(4'd2, 32'd1, dum);
    wr(4'd0, 32'h5, n);
    wr(4'd1, 32'h2, m);
    chk("setwins w1c_edge", 32'(m), 32'(n + 2));
    rd(4'd1, r); chk("setwins status", r, 32'h2);
    chk("setwins irq", 32'(irq), 32'h1);

    // Asynchronous reset in the middle of a strobe
    wr(4'd8, 32'd1, dum); wr(4'd9, 32'd6, dum); wr(4'd2, 32'd2, dum); wr(4'd3, 32'd2, dum);
    sq.delete();
    wr(4'd0, 32'h7, n);
    wait_to(n + 3);
    #1 chk("midrun strobe_active", 32'(m_chipselect), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("midrun_rst m_chipselect", 32'(m_chipselect), 32'h0);
    chk("midrun_rst m_write_n", 32'(m_write_n), 32'h1);
    chk("midrun_rst m_writedata", m_writedata, 32'h0);
    chk("midrun_rst irq", 32'(irq), 32'h0);
    rd(4'd1, r); chk("midrun_rst status", r, 32'h0);
    rd(4'd0, r); chk("midrun_rst ctrl", r, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("midrun_rst no_more_strobes", 32'(sq.size()), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/processador_pio_seq.md
# processador_pio_seq

Pattern sequencer for the 3-bit output PIO of the processador system. Holds up to eight 3-bit patterns plus a dwell time, programmed through its own Avalon-MM slave. On start it drives Avalon-MM write transactions into the PIO data register at fixed intervals, optionally looping. This frees the CPU from bit-banging LED/actuator sequences.

## Interface
- DWELL_W, 16, width of the dwell counter and DWELL register
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- address  in  4  config slave word address
- chipselect  in  1  config slave select
- write_n  in  1  config slave write strobe, active-low
- writedata  in  32  config slave write data
- readdata  out  32  config slave read data, combinational from address; 0 for unmapped addresses
- m_address  out  2  PIO address; constant 0
- m_chipselect  out  1  PIO select
- m_write_n  out  1  PIO write strobe, active-low
- m_writedata  out  32  {29'b0, pattern}
- irq  out  1  level interrupt: STATUS.done & CTRL.ie

## Operation
- Register map (word addresses):
  - 0 CTRL: bit0 run, bit1 loop, bit2 ie.
  - 1 STATUS, read-only except W1C: bit0 busy, bit1 done (write 1 clears), bits[6:4] current index.
  - 2 DWELL[DWELL_W-1:0].
  - 3 LENGTH[2:0]; value 0 means 8 entries.
  - 8-15 PAT[0..7][2:0].
  - 4-7 read 0; writes to them are ignored.
- A slave write occurs when chipselect=1 and write_n=0 at a clk edge.
- FSM states:
  - IDLE: busy=0, index=0. A CTRL write with run=1 clears done and goes to STROBE.
  - STROBE (1 cycle): m_chipselect=1, m_write_n=0, m_writedata=PAT[index]. If DWELL=0, go straight to ADVANCE logic; otherwise load the counter with DWELL and go to WAIT.
  - WAIT: decrement the counter; at 1, advance.
  - Advance:
    - If index < LENGTH-1: index+1, go to STROBE.
    - Else, if loop=1: index=0, go to STROBE.
    - Else: set done, clear run, go to IDLE.
- Abort: a CTRL write with run=0 while busy goes to IDLE next edge. No further strobes, done unchanged, index reset to 0.
- A CTRL write with run=1 while busy does not restart. loop and ie update immediately, so clearing loop mid-run ends after the current pass.
- PAT/DWELL/LENGTH writes while busy are accepted. PAT is sampled at STROBE; DWELL at WAIT entry; LENGTH at advance. If index ≥ new LENGTH-1 at advance, the pass ends (or wraps if loop=1).
- Simultaneous done set and STATUS W1C: set wins.
- Outputs are registered; m_* are deasserted in every state except STROBE.

## Timing
- Reset values: all registers 0, state IDLE, readdata reflects zeros, m_chipselect=0, m_write_n=1, m_writedata=0, m_address=0, irq=0.
- Start latency: the CTRL write is sampled at edge N; the first strobe is in cycle N+1 (between edges N and N+1). The PIO captures at edge N+1.
- Strobe period: DWELL+1 cycles, including DWELL=0, which gives back-to-back strobes.
- done/irq assert at the edge ending the last WAIT (or the last STROBE when DWELL=0). busy=0 from the same edge.
- A reset_n assertion mid-sequence returns to reset values asynchronously. No partial strobe is held.

## Test plan
- Reset: assert reset_n=0 mid-run -> all m_* at reset values, readdata of STATUS=0, irq=0.
- LENGTH=3, PAT={5,2,7}, DWELL=4, run=1 -> writedata 5,2,7 on strobes 5 cycles apart; first strobe 1 cycle after the CTRL write; then done=1, busy=0, CTRL.run reads 0.
- DWELL=0, LENGTH=0 (8 entries), PAT=0..7 -> 8 consecutive single-cycle strobes with values 0..7, then done.
- loop=1, LENGTH=2, PAT={1,6}, DWELL=2 -> sequence 1,6,1,6... every 3 cycles. Clearing loop during a PAT[0] strobe ends after the next 6.
- Abort: write run=0 during WAIT -> no further strobes, done=0, index=0. Restart -> begins at PAT[0].
- ie=1 at completion -> irq=1. STATUS write 0x2 -> irq=0. Reads of addresses 4-7 return 0.
